// File: rtl/mem_arb_pkg.sv
// Shared types for the memory data-port arbiter: FSM states, requester ids, default widths.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that did not win last time goes next.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_win_id,
  output logic o_win_vld
);
  assign o_win_vld = i_req0 | i_req1;
  assign o_win_id  = (i_req0 && i_req1) ? ~i_last_gnt : (i_req1 ? REQ_DBG : REQ_CPU);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the 256x8 async memory data port between CPU (req0) and debug loader (req1).
// Optional write protection of the low address range is enabled by defining MEM_WPROT_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                ADDR_W      = DEF_ADDR_W,
  parameter int                DATA_W      = DEF_DATA_W,
  parameter int                WR_HOLD     = 1,
  parameter logic [ADDR_W-1:0] WPROT_LIMIT = 'h40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              wprot_err
);
  localparam int CNT_W = $clog2(WR_HOLD + 1);
`ifdef MEM_WPROT_EN
  localparam bit WPROT_ON = 1'b1;
`else
  localparam bit WPROT_ON = 1'b0;
`endif

  state_t            r_state, w_next;
  logic              r_id, r_we, r_blk, r_last_gnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_win_id, w_win_vld, w_we_in, w_blk_req;
  logic [ADDR_W-1:0] w_addr_in;
  logic [DATA_W-1:0] w_wdata_in;

  rr_arb2 u_rr_arb2 (
    .i_req0     (req0),
    .i_req1     (req1),
    .i_last_gnt (r_last_gnt),
    .o_win_id   (w_win_id),
    .o_win_vld  (w_win_vld)
  );

  assign w_we_in    = w_win_id ? we1    : we0;
  assign w_addr_in  = w_win_id ? addr1  : addr0;
  assign w_wdata_in = w_win_id ? wdata1 : wdata0;
  assign w_blk_req  = WPROT_ON && w_we_in && (w_addr_in < WPROT_LIMIT);
  assign rdata      = r_rdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Outputs are decoded from the registered state only, so reset clears mem_we at once.
  always_comb begin
    w_next      = r_state;
    gnt0        = 1'b0;
    gnt1        = 1'b0;
    ack0        = 1'b0;
    ack1        = 1'b0;
    mem_we      = 1'b0;
    mem_address = '0;
    mem_data_in = '0;
    wprot_err   = 1'b0;
    if (r_state != ST_IDLE) begin
      mem_address = r_addr;
      mem_data_in = r_wdata;
      gnt0        = (r_id == REQ_CPU);
      gnt1        = (r_id == REQ_DBG);
    end
    case (r_state)
      ST_IDLE:   if (w_win_vld) w_next = ST_ACCESS;
      ST_ACCESS: w_next = (r_we && !r_blk) ? ST_WRITE : ST_DONE;
      ST_WRITE: begin
        mem_we = 1'b1;
        if (r_cnt == CNT_W'(WR_HOLD - 1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        ack0      = (r_id == REQ_CPU);
        ack1      = (r_id == REQ_DBG);
        wprot_err = r_blk;
        w_next    = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Read data is captured leaving ACCESS so it is already valid while ack is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_id       <= REQ_CPU;
      r_we       <= 1'b0;
      r_blk      <= 1'b0;
      r_last_gnt <= REQ_DBG;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_win_vld) begin
          r_id    <= w_win_id;
          r_we    <= w_we_in;
          r_addr  <= w_addr_in;
          r_wdata <= w_wdata_in;
          r_blk   <= w_blk_req;
          r_cnt   <= '0;
        end
        ST_ACCESS: if (!r_we) r_rdata <= mem_data_out;
        ST_WRITE:  r_cnt <= r_cnt + 1'b1;
        ST_DONE:   r_last_gnt <= r_id;
        default: ;
      endcase
    end
  end
endmodule
